// File: rtl/tile_spawner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tile_spawner_pkg
// Purpose  : Shared types for the tile spawner: tile kinds, board points,
//            shape extents, FSM states and the shape pattern table.
// Revision : 1.0 - initial release
// ============================================================================
package tile_spawner_pkg;

    // Coordinate widths are sized for a 16-column by 32-row board
    localparam int c_x_w   = 5;
    localparam int c_y_w   = 6;
    localparam int c_rom_w = 24;
    localparam int c_rom_d = 32;

    typedef enum logic [2:0] {
        eNon = 3'd0,
        eI   = 3'd1,
        eJ   = 3'd2,
        eL   = 3'd3,
        eO   = 3'd4,
        eS   = 3'd5,
        eT   = 3'd6,
        eZ   = 3'd7
    } tile_type_e;

    typedef struct packed {
        logic signed [c_x_w-1:0] x;
        logic signed [c_y_w-1:0] y;
    } point_t;

    typedef struct packed {
        logic [2:0] min_x_m;
        logic [2:0] max_x_m;
        logic [2:0] max_y_m;
    } shape_info_t;

    typedef enum logic [2:0] {
        eIDLE    = 3'd0,
        eFetch   = 3'd1,
        eUpdate  = 3'd2,
        eWaiting = 3'd3,
        eOver    = 3'd4
    } state_t;

    // Shape word: four cells, cell k at bits [6k+5:6k] = {x[2:0], y[2:0]},
    // local box coordinates with y growing downwards. Each quarter turn maps
    // (x,y) -> (n-1-y, x) inside the piece's own bounding box (4 for I, 3
    // for the others); the O piece is rotation invariant.
    function automatic logic [c_rom_w-1:0] shape_word(input logic [4:0] addr);
        logic [3:0][2:0] xs;
        logic [3:0][2:0] ys;
        logic [3:0][2:0] nx;
        logic [2:0]      n_m1;
        logic            spin;
        logic [1:0]      ang;
        logic [c_rom_w-1:0] word;
        ang  = addr[1:0];
        spin = 1'b1;
        n_m1 = 3'd2;
        case (tile_type_e'(addr[4:2]))
            eI: begin xs = {3'd3, 3'd2, 3'd1, 3'd0}; ys = {3'd1, 3'd1, 3'd1, 3'd1}; n_m1 = 3'd3; end
            eJ: begin xs = {3'd2, 3'd1, 3'd0, 3'd0}; ys = {3'd1, 3'd1, 3'd1, 3'd0}; end
            eL: begin xs = {3'd2, 3'd1, 3'd0, 3'd2}; ys = {3'd1, 3'd1, 3'd1, 3'd0}; end
            eO: begin xs = {3'd2, 3'd1, 3'd2, 3'd1}; ys = {3'd1, 3'd1, 3'd0, 3'd0}; spin = 1'b0; end
            eS: begin xs = {3'd1, 3'd0, 3'd2, 3'd1}; ys = {3'd1, 3'd1, 3'd0, 3'd0}; end
            eT: begin xs = {3'd2, 3'd1, 3'd0, 3'd1}; ys = {3'd1, 3'd1, 3'd1, 3'd0}; end
            eZ: begin xs = {3'd2, 3'd1, 3'd1, 3'd0}; ys = {3'd1, 3'd1, 3'd0, 3'd0}; end
            default: begin xs = '0; ys = '0; spin = 1'b0; end
        endcase
        for (int r = 0; r < 3; r++) begin
            if (spin && (2'(r) < ang)) begin
                for (int k = 0; k < 4; k++) begin
                    nx[k] = n_m1 - ys[k];
                end
                ys = xs;
                xs = nx;
            end
        end
        for (int k = 0; k < 4; k++) begin
            word[6*k +: 6] = {xs[k], ys[k]};
        end
        return word;
    endfunction

    // Horizontal extent and lowest row of a shape word
    function automatic shape_info_t shape_info(input logic [c_rom_w-1:0] word);
        shape_info_t info;
        info.min_x_m = 3'd7;
        info.max_x_m = 3'd0;
        info.max_y_m = 3'd0;
        for (int k = 0; k < 4; k++) begin
            if (word[6*k+3 +: 3] < info.min_x_m) info.min_x_m = word[6*k+3 +: 3];
            if (word[6*k+3 +: 3] > info.max_x_m) info.max_x_m = word[6*k+3 +: 3];
            if (word[6*k   +: 3] > info.max_y_m) info.max_y_m = word[6*k   +: 3];
        end
        return info;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tile_spawner_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tile_preview_fifo
// Purpose  : Preview queue of upcoming tiles (type + angle) with count,
//            full and empty flags; pointers wrap modulo depth_p.
// Revision : 1.0 - initial release
// ============================================================================
module tile_preview_fifo
    import tile_spawner_pkg::*;
#(
    parameter int depth_p = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  tile_type_e                   type_i,
    input  logic [1:0]                   angle_i,
    output tile_type_e                   type_o,
    output logic [1:0]                   angle_o,
    output logic [$clog2(depth_p+1)-1:0] count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int c_ptr_w = (depth_p > 1) ? $clog2(depth_p) : 1;
    localparam int c_cnt_w = $clog2(depth_p + 1);

    tile_type_e           r_type_mem  [depth_p];
    logic [1:0]           r_angle_mem [depth_p];
    logic [c_ptr_w-1:0]   r_wr;
    logic [c_ptr_w-1:0]   r_rd;
    logic [c_cnt_w-1:0]   r_count;
    logic                 w_push_ok;
    logic                 w_pop_ok;

    assign full_o    = (r_count == c_cnt_w'(depth_p));
    assign empty_o   = (r_count == '0);
    assign count_o   = r_count;
    assign w_push_ok = push_i & ~full_o;
    assign w_pop_ok  = pop_i & ~empty_o;
    assign type_o    = r_type_mem[r_rd];
    assign angle_o   = r_angle_mem[r_rd];

    // Storage write; contents need no reset because the count gates visibility
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_type_mem[r_wr]  <= type_i;
            r_angle_mem[r_wr] <= angle_i;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop keeps the count
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr <= (r_wr == c_ptr_w'(depth_p - 1)) ? '0 : r_wr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd <= (r_rd == c_ptr_w'(depth_p - 1)) ? '0 : r_rd + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/tile_spawner_rom.sv
`default_nettype none
// ============================================================================
// Module   : memory_pattern
// Purpose  : Shape ROM, combinational read, addressed by {type, angle}.
// Revision : 1.0 - initial release
// ============================================================================
module memory_pattern
    import tile_spawner_pkg::*;
#(
    parameter int width_p = 24,
    parameter int depth_p = 32
) (
    input  logic [$clog2(depth_p)-1:0] addr_i,
    output logic [width_p-1:0]         data_o
);

    // Table contents come from the shared shape function
    assign data_o = width_p'(shape_word(addr_i));

endmodule
`default_nettype wire

// File: rtl/tile_spawner.sv
`default_nettype none
// ============================================================================
// Module   : tile_spawner
// Purpose  : Buffers upcoming tiles, pops one per spawn request, derives the
//            spawn position from the shape ROM, hands the tile to the
//            collision manager and latches game over on a colliding spawn.
// Revision : 1.0 - initial release
// ============================================================================
module tile_spawner
    import tile_spawner_pkg::*;
#(
    parameter int height_p        = 32,
    parameter int width_p         = 16,
    parameter int preview_depth_p = 4,
    parameter int center_mode_p   = 1,
    parameter int debug_p         = 0
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  tile_type_e tile_type_i,
    input  logic [1:0] tile_type_angle_i,
    input  logic       v_i,
    output logic       ready_o,
    output tile_type_e next_type_o,
    output logic [1:0] next_angle_o,
    output logic       next_v_o,
    input  logic       spawn_i,
    output tile_type_e tile_type_o,
    output logic [1:0] tile_type_angle_o,
    output point_t     pos_o,
    output logic       v_o,
    input  logic       cm_is_ready_i,
    input  logic       cm_collide_i,
    output logic       done_o,
    output logic       game_over_o
);

    localparam int c_cnt_w = $clog2(preview_depth_p + 1);

    // Board must fit the signed point fields; tracing is not built into RTL
    if ((width_p > (1 << (c_x_w - 1))) || (height_p > (1 << (c_y_w - 1)))
        || (preview_depth_p < 1) || (debug_p < 0) || (debug_p > 1)) begin : g_bad_params
        $error("tile_spawner: unsupported parameter combination");
    end

    state_t              r_state;
    logic                r_pending;
    tile_type_e          r_type;
    logic [1:0]          r_angle;
    point_t              r_point;
    logic                r_v;
    logic                r_game_over;

    tile_type_e          w_head_type;
    logic [1:0]          w_head_angle;
    logic [c_cnt_w-1:0]  w_count;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_start;
    logic [c_rom_w-1:0]  w_rom_data;
    shape_info_t         w_info;
    int                  w_span;
    int                  w_x_calc;
    point_t              w_spawn_point;

    assign ready_o = ~w_full & ~r_game_over;
    assign w_push  = v_i & ready_o;
    assign w_start = (r_state == eIDLE) & (r_pending | spawn_i) & ~w_empty;

    tile_preview_fifo #(
        .depth_p (preview_depth_p)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (w_push),
        .pop_i   (w_start),
        .type_i  (tile_type_i),
        .angle_i (tile_type_angle_i),
        .type_o  (w_head_type),
        .angle_o (w_head_angle),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign next_v_o     = (w_count != '0);
    assign next_type_o  = w_empty ? eNon  : w_head_type;
    assign next_angle_o = w_empty ? 2'd0  : w_head_angle;

    memory_pattern #(
        .width_p (c_rom_w),
        .depth_p (c_rom_d)
    ) u_rom (
        .addr_i ({r_type, r_angle}),
        .data_o (w_rom_data)
    );

    assign w_info = shape_info(w_rom_data);

    // Spawn position: one row above the board for the shape's lowest cell,
    // x either legacy fixed or centred on the real horizontal extent
    always_comb begin
        w_span   = int'(w_info.max_x_m) - int'(w_info.min_x_m) + 1;
        w_x_calc = (width_p - w_span) / 2 - int'(w_info.min_x_m);
        if (center_mode_p == 0) begin
            w_x_calc = width_p / 2 - 2;
        end
        w_spawn_point.x = c_x_w'(w_x_calc);
        w_spawn_point.y = ~{{(c_y_w - 3){1'b0}}, w_info.max_y_m};
    end

    assign tile_type_o       = r_type;
    assign tile_type_angle_o = r_angle;
    assign pos_o             = r_point;
    assign v_o               = r_v;
    assign game_over_o       = r_game_over;
    assign done_o            = (r_state == eWaiting) & cm_is_ready_i & ~cm_collide_i;

    // Spawn sequencer with merged pending request and registered outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= eIDLE;
            r_pending   <= 1'b0;
            r_type      <= eNon;
            r_angle     <= 2'd0;
            r_point     <= '0;
            r_v         <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_v <= 1'b0;
            if (w_start) begin
                r_pending <= 1'b0;
            end else if (spawn_i && (r_state != eOver)) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                eIDLE: begin
                    if (w_start) begin
                        r_type  <= w_head_type;
                        r_angle <= w_head_angle;
                        r_state <= eFetch;
                    end
                end
                eFetch: begin
                    r_point <= w_spawn_point;
                    r_v     <= 1'b1;
                    r_state <= eUpdate;
                end
                eUpdate: begin
                    r_state <= eWaiting;
                end
                eWaiting: begin
                    if (cm_is_ready_i) begin
                        if (cm_collide_i) begin
                            r_state     <= eOver;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state <= eIDLE;
                        end
                    end
                end
                eOver: begin
                    r_state <= eOver;
                end
                default: begin
                    r_state <= eIDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
